// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage: shift-add MULT/MULTU and
// restoring DIV/DIVU on magnitudes, with a sign-fix cycle, producing registered HI/LO.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 prime_q, prime_d;
  logic                 is_div_q, is_div_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 dbz_q, dbz_d;

  logic                 a_neg, b_neg;
  logic [WIDTH:0]       msum;
  logic [2*WIDTH-1:0]   mul_nx;
  logic [WIDTH:0]       rem_s;
  logic [WIDTH:0]       dsub;
  logic                 dge;
  logic [2*WIDTH-1:0]   div_nx;
  logic [WIDTH-1:0]     quo, rem;

  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];

  // Multiply step: conditional add of the multiplicand into the upper half, then shift right.
  assign msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
  assign mul_nx = {msum, acc_q[WIDTH-1:1]};

  // Divide step: rem_s is the shifted partial remainder; its top bit set means it already
  // exceeds any W-bit divisor, otherwise the borrow of the W+1 bit subtract decides.
  assign rem_s  = acc_q[2*WIDTH-1:WIDTH-1];
  assign dsub   = {1'b0, rem_s[WIDTH-1:0]} - {1'b0, opb_q};
  assign dge    = rem_s[WIDTH] | ~dsub[WIDTH];
  assign div_nx = {(dge ? dsub[WIDTH-1:0] : rem_s[WIDTH-1:0]), acc_q[WIDTH-2:0], dge};

  assign quo = acc_q[WIDTH-1:0];
  assign rem = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prime_d  = prime_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CALC;
          prime_d  = 1'b1;
          is_div_d = op[1];
          sa_d     = a_neg;
          sb_d     = b_neg;
          opa_d    = a_neg ? -a : a;
          opb_d    = b_neg ? -b : b;
          dbz_d    = 1'b0;
        end
      end
      CALC: begin
        // The first CALC cycle seeds the accumulator from the latched magnitudes.
        if (prime_q) begin
          prime_d = 1'b0;
          cnt_d   = CW'(WIDTH - 1);
          acc_d   = is_div_q ? {{WIDTH{1'b0}}, opa_q} : {{WIDTH{1'b0}}, opb_q};
        end else begin
          acc_d = is_div_q ? div_nx : mul_nx;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = FIX;
        end
      end
      FIX: begin
        state_d = DONE;
        if (!is_div_q) begin
          {hi_d, lo_d} = (sa_q ^ sb_q) ? -acc_q : acc_q;
        end else if (opb_q == '0) begin
          hi_d  = sa_q ? -opa_q : opa_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          lo_d = (sa_q ^ sb_q) ? -quo : quo;
          hi_d = sa_q ? -rem : rem;
        end
      end
      DONE: state_d = IDLE;
    endcase

    // Abort wins over everything, including a same-cycle start or result write.
    if (flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prime_q  <= 1'b0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prime_q  <= prime_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, multi-cycle corner sequences
// (flush, async reset, held start) and random operations against an arithmetic model.
module tb_muldiv_unit;

  localparam int unsigned W   = 32;
  localparam int          LAT = 34;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic          flush;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] prev_hi = '0;
  logic [W-1:0] prev_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
    logic         edbz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic reference: {dbz, hi, lo}
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [63:0] sx, sy, q, r;
    logic [63:0] p;
    sx = 64'(signed'(x));
    sy = 64'(signed'(y));
    case (o)
      2'b00: begin p = {32'b0, x} * {32'b0, y}; return {1'b0, p}; end
      2'b01: begin p = sx * sy; return {1'b0, p}; end
      default: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        if (o == 2'b10) return {1'b0, x % y, x / y};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                        input string tag);
    int k;
    @(negedge CLK);
    start = 1'b1; op = o; a = xa; b = xb;
    @(posedge CLK); #1;
    start = 1'b0;
    k = 0;
    chk({tag, "_busy0"}, 64'(busy), 64'd1);
    chk({tag, "_dbzclr"}, 64'(div_by_zero), 64'd0);
    chk({tag, "_hold"}, {hi, lo}, {prev_hi, prev_lo});
    while (k < 100 && !done) begin
      @(posedge CLK); #1;
      k++;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: no done after %0d cycles, required %0d", tag, k, LAT);
    end else begin
      chk({tag, "_lat"}, 64'(k), 64'(LAT));
      chk({tag, "_hilo"}, {hi, lo}, {ehi, elo});
      chk({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
      chk({tag, "_busyD"}, 64'(busy), 64'd0);
    end
    prev_hi = ehi;
    prev_lo = elo;
    @(posedge CLK); #1;
    chk({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK); #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    vec_t vt[10];
    logic [2*W:0] m;
    logic [W-1:0] ra, rb;
    logic [1:0]   ro;
    int dcnt, first_d, second_d;

    vt[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vt[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vt[2] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vt[3] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vt[4] = '{2'b10, 32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    vt[5] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
    vt[6] = '{2'b11, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vt[7] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
    vt[8] = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vt[9] = '{2'b00, 32'h0,         32'hDEAD_BEEF, 32'h0,         32'h0,         1'b0};

    nRST = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    #12;
    chk("reset_state", {59'b0, busy, done, div_by_zero, 2'b0}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(negedge CLK); nRST = 1'b1;

    foreach (vt[i]) run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].ehi, vt[i].elo, vt[i].edbz, $sformatf("vec%0d", i));

    // Flush mid-multiply: no done, results untouched, then a re-issue works.
    @(negedge CLK);
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
    @(posedge CLK); #1; start = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK); flush = 1'b1;
    @(posedge CLK); #1; flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    count_done(40, dcnt);
    chk("flush_nodone", 64'(dcnt), 64'd0);
    chk("flush_hilo", {hi, lo}, {prev_hi, prev_lo});
    @(negedge CLK);
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    @(posedge CLK); #1; start = 1'b0; flush = 1'b0;
    chk("flush_prio", 64'(busy), 64'd0);
    run_op(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, "reissue");

    // Asynchronous reset in the middle of a divide.
    @(negedge CLK);
    start = 1'b1; op = 2'b11; a = 32'h8765_4321; b = 32'd99;
    @(posedge CLK); #1; start = 1'b0;
    repeat (19) @(posedge CLK);
    #3 nRST = 1'b0;
    #1;
    chk("rst_mid_flags", {61'b0, busy, done, div_by_zero}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    prev_hi = '0; prev_lo = '0;
    @(negedge CLK); nRST = 1'b1;
    count_done(40, dcnt);
    chk("rst_nodone", 64'(dcnt), 64'd0);

    // Start held high: one result per issue, minimum spacing of WIDTH+4.
    @(negedge CLK);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(posedge CLK); #1;
    dcnt = 0; first_d = -1; second_d = -1;
    for (int k = 0; k < 90; k++) begin
      if (done) begin
        dcnt++;
        if (first_d < 0) first_d = k;
        else if (second_d < 0) second_d = k;
      end
      if (k == 40) begin
        @(negedge CLK); start = 1'b0;
      end
      @(posedge CLK); #1;
    end
    chk("hold_count", 64'(dcnt), 64'd2);
    chk("hold_first", 64'(first_d), 64'(LAT));
    chk("hold_interval", 64'(second_d - first_d), 64'(W + 4));
    chk("hold_hilo", {hi, lo}, {32'd2, 32'd14});
    prev_hi = 32'd2; prev_lo = 32'd14;

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: ra = 32'($urandom_range(0, 255));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'($urandom_range(0, 3));
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(0, 65535));
        default: rb = $urandom;
      endcase
      m = model(ro, ra, rb);
      run_op(ro, ra, rb, m[2*W-1:W], m[W-1:0], m[2*W], $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
